// File: rtl/spi_msg_forwarder.sv
// Forwards buffered SPI messages from the receive FIFO to a transmit channel, word by word.
// Ports:
//   SYS_CLK, RST         clock, synchronous active-high reset
//   GOT_FULL_MSG/MSG_LEN receive side has a complete message of MSG_LEN 16-bit words
//   MSG_START            one-cycle acknowledge that the message is being consumed
//   RD_REQ/FIFO_Q        FIFO read strobe; data arrives one cycle later
//   DATA/ENA/BUSY        transmit channel handshake
//   TIMEOUT_ERR          one-cycle pulse when a word is abandoned because BUSY stuck high
//   FWD_CNT              count of fully forwarded messages (wraps)
//   IDLE                 high while waiting for a message
module spi_msg_forwarder #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CNT_W          = 16,
   localparam int unsigned LEN_W         = 8,
   localparam int unsigned WORD_W        = 16
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   input  logic              GOT_FULL_MSG,
   input  logic [LEN_W-1:0]  MSG_LEN,
   output logic              MSG_START,
   output logic              RD_REQ,
   input  logic [WORD_W-1:0] FIFO_Q,
   output logic [WORD_W-1:0] DATA,
   output logic              ENA,
   input  logic              BUSY,
   output logic              TIMEOUT_ERR,
   output logic [CNT_W-1:0]  FWD_CNT,
   output logic              IDLE
);

   localparam int unsigned TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_READ, S_LATCH, S_SEND, S_GUARD, S_DRAIN_RD, S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [LEN_W-1:0]    rem, rem_nxt;
   logic [TMO_W-1:0]    tmo, tmo_nxt;
   logic [WORD_W-1:0]   data_nxt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                ena_nxt, terr_nxt, rd_nxt;

   // Next-state and next-output decode
   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      tmo_nxt   = tmo;
      data_nxt  = DATA;
      cnt_nxt   = FWD_CNT;
      ena_nxt   = 1'b0;
      terr_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (GOT_FULL_MSG) begin
               rem_nxt   = MSG_LEN;
               state_nxt = S_START;
            end
         end
         S_START:  state_nxt = (rem == '0) ? S_DONE : S_READ;
         S_READ:   state_nxt = S_LATCH;
         S_LATCH: begin
            data_nxt  = FIFO_Q;
            tmo_nxt   = '0;
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (!BUSY) begin
               ena_nxt = 1'b1;
               if (rem != '0) rem_nxt = rem - LEN_W'(1);
               state_nxt = S_GUARD;
            end else if (TMO_EN && (tmo == TMO_W'(TMO_LAST))) begin
               // current word is dropped; the rest of the message gets drained
               terr_nxt = 1'b1;
               if (rem != '0) rem_nxt = rem - LEN_W'(1);
               state_nxt = S_DRAIN_RD;
            end else begin
               tmo_nxt = tmo + TMO_W'(1);
            end
         end
         S_GUARD: begin
            if (rem == '0) begin
               cnt_nxt   = FWD_CNT + CNT_W'(1);
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_READ;
            end
         end
         S_DRAIN_RD: begin
            if (rem != '0) rem_nxt = rem - LEN_W'(1);
            else           state_nxt = S_DONE;
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // A drain cycle reads only while words remain, i.e. while rem entering it is nonzero
   always_comb begin
      rd_nxt = (state_nxt == S_READ) || ((state_nxt == S_DRAIN_RD) && (rem_nxt != '0));
   end

   // State, datapath and output registers
   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         rem         <= '0;
         tmo         <= '0;
         DATA        <= '0;
         FWD_CNT     <= '0;
         ENA         <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         MSG_START   <= 1'b0;
         RD_REQ      <= 1'b0;
         IDLE        <= 1'b1;
      end else begin
         state       <= state_nxt;
         rem         <= rem_nxt;
         tmo         <= tmo_nxt;
         DATA        <= data_nxt;
         FWD_CNT     <= cnt_nxt;
         ENA         <= ena_nxt;
         TIMEOUT_ERR <= terr_nxt;
         MSG_START   <= (state_nxt == S_START);
         RD_REQ      <= rd_nxt;
         IDLE        <= (state_nxt == S_IDLE);
      end
   end

endmodule

// File: tb/tb_spi_msg_forwarder.sv
// Self-checking bench for spi_msg_forwarder: unit 0 uses an 8-cycle BUSY timeout,
// unit 1 the default timeout. A FIFO model and a BUSY model respond to each unit.
module tb_spi_msg_forwarder;
   localparam int unsigned CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              got       [2];
   logic [7:0]        len       [2];
   logic [15:0]       fifo_q    [2];
   logic              busy      [2];
   logic              msg_start [2];
   logic              rd_req    [2];
   logic              ena       [2];
   logic              terr      [2];
   logic              idle      [2];
   logic [15:0]       data      [2];
   logic [CNT_W-1:0]  fwd_cnt   [2];

   spi_msg_forwarder #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut_t8 (
      .SYS_CLK(clk), .RST(rst), .GOT_FULL_MSG(got[0]), .MSG_LEN(len[0]),
      .MSG_START(msg_start[0]), .RD_REQ(rd_req[0]), .FIFO_Q(fifo_q[0]),
      .DATA(data[0]), .ENA(ena[0]), .BUSY(busy[0]), .TIMEOUT_ERR(terr[0]),
      .FWD_CNT(fwd_cnt[0]), .IDLE(idle[0]));

   spi_msg_forwarder #(.CNT_W(CNT_W)) dut_def (
      .SYS_CLK(clk), .RST(rst), .GOT_FULL_MSG(got[1]), .MSG_LEN(len[1]),
      .MSG_START(msg_start[1]), .RD_REQ(rd_req[1]), .FIFO_Q(fifo_q[1]),
      .DATA(data[1]), .ENA(ena[1]), .BUSY(busy[1]), .TIMEOUT_ERR(terr[1]),
      .FWD_CNT(fwd_cnt[1]), .IDLE(idle[1]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // FIFO and transmit-channel models
   logic [15:0] mem [2][512];
   int wr_ptr    [2] = '{0, 0};
   int rd_ptr    [2] = '{0, 0};
   int busy_hold [2] = '{0, 0};
   int busy_cnt  [2] = '{0, 0};

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst)             rd_ptr[i] <= wr_ptr[i];
         else if (rd_req[i]) begin
            fifo_q[i] <= mem[i][rd_ptr[i][8:0]];
            rd_ptr[i] <= rd_ptr[i] + 1;
         end
         if (busy_hold[i] == 0) busy_cnt[i] <= 0;
         else if (ena[i])       busy_cnt[i] <= busy_hold[i];
         else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
      end
   end
   assign busy[0] = (busy_cnt[0] != 0);
   assign busy[1] = (busy_cnt[1] != 0);

   // Scoreboard: words that must reach ENA, in order; 'last' marks a message that completes
   typedef struct { logic [15:0] d; bit last; } exp_t;
   exp_t exp_q [$];
   int exp_fwd [2] = '{0, 0};
   int n_ena [2] = '{0, 0};
   int n_rd [2] = '{0, 0};
   int n_start [2] = '{0, 0};
   int n_terr [2] = '{0, 0};
   int ena_cyc [$];
   int start_cyc [$];
   int terr_cyc = 0;
   int act = 0;
   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_chk++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Per-cycle compare against the scoreboard
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         for (int i = 0; i < 2; i++) begin
            if (ena[i]) begin
               n_ena[i]++;
               chk("ena_while_busy", 32'(busy[i]), 32'd0);
               chk("ena_unit", 32'(i), 32'(act));
               if (i == act) begin
                  ena_cyc.push_back(cyc);
                  chk("ena_expected", 32'(exp_q.size() > 0), 32'd1);
                  if (exp_q.size() > 0) begin
                     exp_t e;
                     e = exp_q.pop_front();
                     chk("ena_data", 32'(data[i]), 32'(e.d));
                     if (e.last) exp_fwd[i]++;
                  end
               end
            end
            if (idle[i]) begin
               chk("fwd_cnt", 32'(fwd_cnt[i]), 32'(exp_fwd[i]));
               chk("idle_quiet", 32'({msg_start[i], rd_req[i], ena[i], terr[i]}), 32'd0);
            end
            if (msg_start[i]) begin
               n_start[i]++;
               if (i == act) start_cyc.push_back(cyc);
            end
            if (rd_req[i]) begin
               n_rd[i]++;
               chk("fifo_underflow", 32'(rd_ptr[i] < wr_ptr[i]), 32'd1);
            end
            if (terr[i]) begin
               n_terr[i]++;
               if (i == act) terr_cyc = cyc;
            end
         end
      end
   end

   task automatic push(input int i, input logic [15:0] w, input bit fwd, input bit last);
      mem[i][wr_ptr[i][8:0]] = w;
      wr_ptr[i]++;
      if (fwd) exp_q.push_back('{d: w, last: last});
   endtask

   task automatic wait_idle(input int i, input int budget, output int c);
      bit seen = 1'b0;
      c = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (idle[i]) begin seen = 1'b1; c = cyc; end
      end
      if (!seen) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_start(input int i, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (msg_start[i]) seen = 1'b1;
      end
      if (!seen) chk("start_timeout", 32'd0, 32'd1);
   endtask

   // Raise GOT_FULL_MSG once the unit is idle; g is the cycle it is first seen
   task automatic launch(input int i, input logic [7:0] l, output int g);
      int c;
      wait_idle(i, 200, c);
      @(posedge clk); #1;
      got[i] = 1'b1;
      len[i] = l;
      @(negedge clk);
      g = cyc;
   endtask

   task automatic clear_logs();
      ena_cyc.delete();
      start_cyc.delete();
   endtask

   initial begin
      int g, g2, ic, b_ena, b_rd, b_start, b_terr;
      got = '{1'b0, 1'b0};
      len = '{8'd0, 8'd0};
      repeat (3) @(posedge clk);
      @(negedge clk);
      // Reset values
      for (int i = 0; i < 2; i++) begin
         chk("rst_idle", 32'(idle[i]), 32'd1);
         chk("rst_fwd", 32'(fwd_cnt[i]), 32'd0);
         chk("rst_data", 32'(data[i]), 32'd0);
         chk("rst_strobes", 32'({msg_start[i], rd_req[i], ena[i], terr[i]}), 32'd0);
      end
      @(posedge clk); #1 rst = 1'b0;

      // 1: three-word message, BUSY low
      act = 0; clear_logs();
      push(0, 16'h1234, 1, 0); push(0, 16'h5678, 1, 0); push(0, 16'h9ABC, 1, 1);
      b_ena = n_ena[0]; b_rd = n_rd[0];
      launch(0, 8'd3, g);
      wait_start(0, 10); got[0] = 1'b0;
      wait_idle(0, 100, ic);
      chk("t1_start_lat", 32'(start_cyc.size() > 0 ? start_cyc[0] - g : -1), 32'd1);
      chk("t1_ena_cnt", 32'(n_ena[0] - b_ena), 32'd3);
      chk("t1_rd_cnt", 32'(n_rd[0] - b_rd), 32'd3);
      if (ena_cyc.size() == 3) begin
         chk("t1_first_ena", 32'(ena_cyc[0] - g), 32'd5);
         chk("t1_space1", 32'(ena_cyc[1] - ena_cyc[0]), 32'd4);
         chk("t1_space2", 32'(ena_cyc[2] - ena_cyc[1]), 32'd4);
      end
      chk("t1_fwd", 32'(fwd_cnt[0]), 32'd1);
      chk("t1_data_hold", 32'(data[0]), 32'h9ABC);
      chk("t1_drained", 32'(exp_q.size()), 32'd0);

      // 2: zero-length message
      clear_logs();
      b_ena = n_ena[0]; b_rd = n_rd[0]; b_start = n_start[0];
      launch(0, 8'd0, g);
      wait_start(0, 10); got[0] = 1'b0;
      wait_idle(0, 20, ic);
      chk("t2_idle_back", 32'(ic - g), 32'd3);
      chk("t2_start_cnt", 32'(n_start[0] - b_start), 32'd1);
      chk("t2_rd_cnt", 32'(n_rd[0] - b_rd), 32'd0);
      chk("t2_ena_cnt", 32'(n_ena[0] - b_ena), 32'd0);
      chk("t2_fwd", 32'(fwd_cnt[0]), 32'd1);

      // 3: BUSY high 10 cycles after each ENA, default timeout unit
      act = 1; clear_logs(); busy_hold[1] = 10;
      push(1, 16'hA5A5, 1, 0); push(1, 16'h0F0F, 1, 1);
      b_ena = n_ena[1];
      launch(1, 8'd2, g);
      wait_start(1, 10); got[1] = 1'b0;
      wait_idle(1, 200, ic);
      chk("t3_ena_cnt", 32'(n_ena[1] - b_ena), 32'd2);
      if (ena_cyc.size() == 2) begin
         chk("t3_first_ena", 32'(ena_cyc[0] - g), 32'd5);
         chk("t3_busy_gap", 32'(ena_cyc[1] - ena_cyc[0]), 32'd12);
      end
      chk("t3_fwd", 32'(fwd_cnt[1]), 32'd1);
      chk("t3_no_terr", 32'(n_terr[1]), 32'd0);
      busy_hold[1] = 0;

      // 4: BUSY stuck after first ENA, 8-cycle timeout
      act = 0; clear_logs(); busy_hold[0] = 100000;
      push(0, 16'hC001, 1, 0); push(0, 16'hC002, 0, 0);
      push(0, 16'hC003, 0, 0); push(0, 16'hC004, 0, 0);
      b_ena = n_ena[0]; b_rd = n_rd[0]; b_terr = n_terr[0];
      launch(0, 8'd4, g);
      wait_start(0, 10); got[0] = 1'b0;
      wait_idle(0, 100, ic);
      chk("t4_terr_cnt", 32'(n_terr[0] - b_terr), 32'd1);
      chk("t4_terr_time", 32'(terr_cyc - g), 32'd16);
      chk("t4_rd_cnt", 32'(n_rd[0] - b_rd), 32'd4);
      chk("t4_ena_cnt", 32'(n_ena[0] - b_ena), 32'd1);
      chk("t4_idle_back", 32'(ic - g), 32'd20);
      chk("t4_fwd", 32'(fwd_cnt[0]), 32'd1);
      chk("t4_fifo_empty", 32'(wr_ptr[0] - rd_ptr[0]), 32'd0);
      busy_hold[0] = 0;

      // 5: reset while in SEND, then a one-word message
      clear_logs();
      for (int k = 0; k < 5; k++) push(0, 16'(16'hD000 + k), 1, k == 4);
      launch(0, 8'd5, g);
      wait_start(0, 10); got[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      exp_fwd = '{0, 0};
      @(negedge clk);
      chk("t5_rst_idle", 32'(idle[0]), 32'd1);
      chk("t5_rst_start", 32'(msg_start[0]), 32'd0);
      chk("t5_rst_rd", 32'(rd_req[0]), 32'd0);
      chk("t5_rst_ena", 32'(ena[0]), 32'd0);
      chk("t5_rst_terr", 32'(terr[0]), 32'd0);
      chk("t5_rst_data", 32'(data[0]), 32'd0);
      chk("t5_rst_fwd", 32'(fwd_cnt[0]), 32'd0);
      chk("t5_rst_fwd_u1", 32'(fwd_cnt[1]), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      clear_logs();
      push(0, 16'h4321, 1, 1);
      b_ena = n_ena[0];
      launch(0, 8'd1, g2);
      wait_start(0, 10); got[0] = 1'b0;
      wait_idle(0, 100, ic);
      chk("t5_ena_cnt", 32'(n_ena[0] - b_ena), 32'd1);
      if (ena_cyc.size() == 1) chk("t5_first_ena", 32'(ena_cyc[0] - g2), 32'd5);
      chk("t5_data", 32'(data[0]), 32'h4321);
      chk("t5_fwd", 32'(fwd_cnt[0]), 32'd1);

      // 6: back-to-back messages of lengths 2 and 1
      clear_logs();
      push(0, 16'h1111, 1, 0); push(0, 16'h2222, 1, 1); push(0, 16'h3333, 1, 1);
      b_ena = n_ena[0]; b_start = n_start[0];
      launch(0, 8'd2, g);
      wait_start(0, 10);
      len[0] = 8'd1;
      wait_start(0, 30); got[0] = 1'b0;
      wait_idle(0, 100, ic);
      chk("t6_start_cnt", 32'(n_start[0] - b_start), 32'd2);
      if (start_cyc.size() == 2) chk("t6_start_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd11);
      chk("t6_ena_cnt", 32'(n_ena[0] - b_ena), 32'd3);
      if (ena_cyc.size() == 3) chk("t6_third_ena", 32'(ena_cyc[2] - g), 32'd16);
      chk("t6_fwd", 32'(fwd_cnt[0]), 32'd3);
      chk("t6_drained", 32'(exp_q.size()), 32'd0);

      // 7: maximum length message
      clear_logs();
      for (int k = 0; k < 255; k++) push(0, 16'(k * 257) ^ 16'h5A5A, 1, k == 254);
      b_ena = n_ena[0]; b_rd = n_rd[0];
      launch(0, 8'd255, g);
      wait_start(0, 10); got[0] = 1'b0;
      wait_idle(0, 1200, ic);
      chk("t7_ena_cnt", 32'(n_ena[0] - b_ena), 32'd255);
      chk("t7_rd_cnt", 32'(n_rd[0] - b_rd), 32'd255);
      chk("t7_idle_back", 32'(ic - g), 32'd1023);
      chk("t7_fwd", 32'(fwd_cnt[0]), 32'd4);
      chk("t7_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
